// File: rtl/dec1_16_timer.sv
// 16-bit countdown timer on a ripple-borrow decrement chain.
// Emits a one-cycle tick on expiry; one-shot or periodic auto-reload; sticky expired/overrun.
module dec1_16_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        reload_mode,
    input  logic        ack,
    output logic [15:0] cnt,
    output logic        busy,
    output logic        tick,
    output logic        expired,
    output logic        overrun
);
    localparam int unsigned W = 16;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] reload_q, reload_d;
    logic         tick_q, tick_d;
    logic         expired_q, expired_d;
    logic         overrun_q, overrun_d;
    logic [W-1:0] borrow_c;
    logic [W-1:0] dec_c;
    logic         expiry_c;

    // Ripple-borrow subtract-one: a bit flips while every lower bit is zero.
    always_comb begin
        borrow_c    = '0;
        borrow_c[0] = 1'b1;
        for (int i = 1; i < int'(W); i++) begin
            borrow_c[i] = borrow_c[i-1] & ~cnt_q[i-1];
        end
        dec_c = cnt_q ^ borrow_c;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        tick_d    = 1'b0;
        expiry_c  = 1'b0;
        expired_d = expired_q;
        overrun_d = overrun_q;

        if (clear) begin
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (load) begin
            cnt_d    = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? S_RUN : S_IDLE;
        end else if (state_q == S_RUN && en) begin
            if (cnt_q == W'(1)) begin
                expiry_c = 1'b1;
                tick_d   = 1'b1;
                if (reload_mode) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end else begin
                cnt_d = dec_c;
            end
        end

        // A fresh expiry outranks ack for expired; ack always clears overrun.
        if (ack) begin
            overrun_d = 1'b0;
        end else if (expiry_c && expired_q) begin
            overrun_d = 1'b1;
        end
        if (expiry_c) begin
            expired_d = 1'b1;
        end else if (ack) begin
            expired_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            reload_q  <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            overrun_q <= overrun_d;
        end
    end

    assign cnt     = cnt_q;
    assign busy    = (state_q == S_RUN);
    assign tick    = tick_q;
    assign expired = expired_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_dec1_16_timer.sv
// Bench for dec1_16_timer: per-cycle vector table plus periodic-timing sequences.
module tb_dec1_16_timer;
    logic        clk = 1'b0;
    logic        rst_n, clear, load, en, reload_mode, ack;
    logic [15:0] load_val;
    logic [15:0] cnt;
    logic        busy, tick, expired, overrun;

    int passed = 0;
    int total  = 0;

    dec1_16_timer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .reload_mode(reload_mode), .ack(ack), .cnt(cnt), .busy(busy),
        .tick(tick), .expired(expired), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, clr, ld;
        logic [15:0] lv;
        logic        en, rm, ack;
        logic [15:0] e_cnt;
        logic [3:0]  e_flags;  // {busy, tick, expired, overrun}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic c, input logic l, input logic [15:0] v,
                                input logic e, input logic m, input logic a,
                                input logic [15:0] ec, input logic [3:0] ef);
        vec_t t;
        t.rst_n = r; t.clr = c; t.ld = l; t.lv = v; t.en = e; t.rm = m; t.ack = a;
        t.e_cnt = ec; t.e_flags = ef;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        en = 1'b0; reload_mode = 1'b0; ack = 1'b0;
    endtask

    initial begin
        int tick_at[$];
        int waited;
        string nm;
        idle_inputs();
        rst_n = 1'b0;

        //   rst clr ld  lv       en rm ack   cnt      {busy,tick,exp,ovr}
        add(0, 0, 0, 16'h0000, 0, 0, 0,  16'h0000, 4'b0000); // reset
        add(1, 0, 1, 16'd5,    1, 0, 0,  16'd5,    4'b1000); // load 5
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd4,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd3,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd2,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd1,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0110); // one-shot expiry
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0010); // idle ignores en
        add(1, 0, 0, 16'd0,    0, 0, 1,  16'd0,    4'b0000); // ack
        add(1, 0, 1, 16'h8000, 0, 0, 0,  16'h8000, 4'b1000); // borrow chain
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'h7FFF, 4'b1000);
        add(1, 0, 1, 16'h0100, 0, 0, 0,  16'h0100, 4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'h00FF, 4'b1000);
        add(1, 0, 1, 16'hFFFF, 0, 0, 0,  16'hFFFF, 4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'hFFFE, 4'b1000);
        add(1, 0, 1, 16'd4,    0, 0, 0,  16'd4,    4'b1000); // en gaps
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd3,    4'b1000);
        add(1, 0, 0, 16'd0,    0, 0, 0,  16'd3,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd2,    4'b1000);
        add(1, 0, 0, 16'd0,    0, 0, 0,  16'd2,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd1,    4'b1000);
        add(1, 0, 0, 16'd0,    0, 0, 0,  16'd1,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0110);
        add(1, 0, 0, 16'd0,    0, 0, 1,  16'd0,    4'b0000);
        add(1, 0, 1, 16'd9,    0, 0, 0,  16'd9,    4'b1000); // clear beats load
        add(1, 1, 1, 16'd6,    0, 0, 0,  16'd0,    4'b0000);
        add(1, 0, 1, 16'd2,    1, 0, 0,  16'd2,    4'b1000); // load beats expiry
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd1,    4'b1000);
        add(1, 0, 1, 16'd7,    1, 0, 0,  16'd7,    4'b1000);
        add(1, 0, 1, 16'd1,    0, 0, 0,  16'd1,    4'b1000); // overrun build-up
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0110);
        add(1, 0, 1, 16'd1,    0, 0, 0,  16'd1,    4'b1010);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0111);
        add(1, 0, 1, 16'd1,    0, 0, 0,  16'd1,    4'b1011);
        add(1, 0, 0, 16'd0,    1, 0, 1,  16'd0,    4'b0110); // ack with tick
        add(1, 1, 0, 16'd0,    0, 0, 0,  16'd0,    4'b0010); // clear keeps flags
        add(1, 0, 1, 16'd0,    0, 0, 0,  16'd0,    4'b0010); // load zero
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0010);
        add(1, 0, 1, 16'd9,    0, 0, 0,  16'd9,    4'b1010); // reset mid-count
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd8,    4'b1010);
        add(1, 0, 0, 16'd0,    1, 0, 0,  16'd7,    4'b1010);
        add(0, 0, 0, 16'd0,    1, 0, 0,  16'd0,    4'b0000);
        add(1, 0, 1, 16'd3,    0, 1, 0,  16'd3,    4'b1000); // periodic 3
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd2,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd1,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd3,    4'b1110);
        add(1, 0, 0, 16'd0,    1, 1, 1,  16'd2,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd1,    4'b1000);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd3,    4'b1110);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd2,    4'b1010);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd1,    4'b1010);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd3,    4'b1111);
        add(1, 0, 0, 16'd0,    1, 1, 0,  16'd2,    4'b1011);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; clear = vecs[i].clr; load = vecs[i].ld;
            load_val = vecs[i].lv; en = vecs[i].en; reload_mode = vecs[i].rm; ack = vecs[i].ack;
            @(posedge clk);
            #1;
            nm = $sformatf("vec%0d", i);
            chk({nm, "_cnt"},   32'(cnt), 32'(vecs[i].e_cnt));
            chk({nm, "_flags"}, 32'({busy, tick, expired, overrun}), 32'(vecs[i].e_flags));
        end

        // Periodic N=4: ticks exactly 4 cycles apart, cnt reloaded at each tick.
        @(negedge clk);
        idle_inputs();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; load = 1'b1; load_val = 16'd4; reload_mode = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                tick_at.push_back(c);
                chk("per4_cnt_at_tick", 32'(cnt), 32'd4);
            end
        end
        chk("per4_tick_count", 32'(tick_at.size()), 32'd3);
        if (tick_at.size() == 3) begin
            chk("per4_first_tick", 32'(tick_at[0]), 32'd4);
            chk("per4_period_a", 32'(tick_at[1] - tick_at[0]), 32'd4);
            chk("per4_period_b", 32'(tick_at[2] - tick_at[1]), 32'd4);
        end

        // Switch to one-shot mid-count: next expiry stops the timer.
        @(negedge clk);
        reload_mode = 1'b0;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!tick && waited < 10);
        chk("oneshot_switch_wait", 32'(waited), 32'd4);
        chk("oneshot_switch_cnt", 32'(cnt), 32'd0);
        chk("oneshot_switch_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("tick_one_cycle", 32'(tick), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
